// File: rtl/net_measure_ctrl_if.sv
// Network-facing signals of the measurement controller: source injections,
// sink receptions with their measure tag, latency and hop count, and the tag enable.
interface net_measure_ctrl_if #(
  parameter int PORTS = 16,
  parameter int LAT_W = 24,
  parameter int HOP_W = 8
);
  logic [PORTS-1:0]       tx_inject;
  logic [PORTS-1:0]       rx_valid;
  logic [PORTS-1:0]       rx_measure;
  logic [PORTS*LAT_W-1:0] rx_latency;
  logic [PORTS*HOP_W-1:0] rx_hops;
  logic                   measure_en;

  modport master (
    output tx_inject, rx_valid, rx_measure, rx_latency, rx_hops,
    input  measure_en
  );

  modport slave (
    input  tx_inject, rx_valid, rx_measure, rx_latency, rx_hops,
    output measure_en
  );
endinterface

// File: rtl/net_measure_ctrl.sv
// Measurement run sequencer: warm-up, measure and drain phases, tagged-packet
// statistics with saturating accumulators, and per-batch latency sums.
module net_measure_ctrl #(
  parameter int PORTS         = 16,
  parameter int LAT_W         = 24,
  parameter int HOP_W         = 8,
  parameter int ACC_W         = 32,
  parameter int WARMUP_PKTS   = 1000,
  parameter int MEASURE_PKTS  = 10000,
  parameter int BATCH         = 50,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  net_measure_ctrl_if.slave    net,
  output logic [2:0]           phase,
  output logic                 done,
  output logic                 timeout,
  output logic [ACC_W-1:0]     total_in,
  output logic [ACC_W-1:0]     total_out,
  output logic [ACC_W-1:0]     meas_in,
  output logic [ACC_W-1:0]     meas_out,
  output logic [ACC_W-1:0]     lat_sum,
  output logic [ACC_W-1:0]     hop_sum,
  output logic                 batch_strobe,
  output logic [ACC_W-1:0]     batch_lat,
  output logic                 overflow
);

  localparam int CNT_W  = $clog2(PORTS + 1);
  localparam int LSUM_W = LAT_W + CNT_W;
  localparam int HSUM_W = HOP_W + CNT_W;
  localparam int W0     = (ACC_W > LSUM_W) ? ACC_W : LSUM_W;
  localparam int W1     = (W0 > HSUM_W) ? W0 : HSUM_W;
  // Working width: wide enough for any per-cycle sum and for 32-bit thresholds.
  localparam int W      = ((W1 > 32) ? W1 : 32) + 1;
  localparam int BC_W   = $clog2(BATCH + PORTS + 1);
  localparam int DC_W   = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_WARMUP  = 3'd1,
    PH_MEASURE = 3'd2,
    PH_DRAIN   = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [PORTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Returns {saturated, clamped sum}; a clamped accumulator stays at its maximum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = (W+1)'(a) + (W+1)'(b);
    if (s > (W+1)'(ACC_MAX)) begin
      return {1'b1, ACC_MAX};
    end else begin
      return {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  phase_e           phase_r;
  logic             measure_en_r;
  logic             done_r;
  logic             timeout_r;
  logic             overflow_r;
  logic             batch_strobe_r;
  logic [ACC_W-1:0] total_in_r;
  logic [ACC_W-1:0] total_out_r;
  logic [ACC_W-1:0] meas_in_r;
  logic [ACC_W-1:0] meas_out_r;
  logic [ACC_W-1:0] lat_sum_r;
  logic [ACC_W-1:0] hop_sum_r;
  logic [ACC_W-1:0] batch_lat_r;
  logic [ACC_W-1:0] batch_acc_r;
  logic [BC_W-1:0]  batch_cnt_r;
  logic [DC_W-1:0]  drain_cnt_r;

  logic [PORTS-1:0] tagged_s;
  logic [CNT_W-1:0] ni_s;
  logic [CNT_W-1:0] no_s;
  logic [CNT_W-1:0] nm_s;
  logic [W-1:0]     lat_cyc_s;
  logic [W-1:0]     hop_cyc_s;
  logic [ACC_W:0]   tin_sat_s;
  logic [ACC_W:0]   tout_sat_s;
  logic [ACC_W:0]   min_sat_s;
  logic [ACC_W:0]   mout_sat_s;
  logic [ACC_W:0]   lat_sat_s;
  logic [ACC_W:0]   hop_sat_s;
  logic [ACC_W:0]   bacc_sat_s;
  logic [BC_W-1:0]  bsum_s;
  logic [DC_W-1:0]  drain_next_s;
  logic             batch_hit_s;
  logic             warm_hit_s;
  logic             meas_hit_s;
  logic             drain_match_s;
  logic             drain_to_s;
  logic             ovf_s;

  // Per-cycle counts, tagged sums, saturated next values and phase-exit conditions.
  always_comb begin
    tagged_s  = net.rx_valid & net.rx_measure;
    ni_s      = popcount(net.tx_inject);
    no_s      = popcount(net.rx_valid);
    nm_s      = popcount(tagged_s);
    lat_cyc_s = {W{1'b0}};
    hop_cyc_s = {W{1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      lat_cyc_s = lat_cyc_s + (tagged_s[k] ? W'(net.rx_latency[k*LAT_W +: LAT_W]) : {W{1'b0}});
      hop_cyc_s = hop_cyc_s + (tagged_s[k] ? W'(net.rx_hops[k*HOP_W +: HOP_W]) : {W{1'b0}});
    end
    tin_sat_s     = sat_add(total_in_r, W'(ni_s));
    tout_sat_s    = sat_add(total_out_r, W'(no_s));
    min_sat_s     = sat_add(meas_in_r, W'(ni_s));
    mout_sat_s    = sat_add(meas_out_r, W'(nm_s));
    lat_sat_s     = sat_add(lat_sum_r, lat_cyc_s);
    hop_sat_s     = sat_add(hop_sum_r, hop_cyc_s);
    bacc_sat_s    = sat_add(batch_acc_r, lat_cyc_s);
    bsum_s        = batch_cnt_r + BC_W'(nm_s);
    batch_hit_s   = (bsum_s >= BC_W'(BATCH));
    warm_hit_s    = ((W'(total_in_r) + W'(ni_s)) >= W'(WARMUP_PKTS));
    meas_hit_s    = ((W'(meas_in_r) + W'(ni_s)) >= W'(MEASURE_PKTS));
    drain_match_s = ((W'(meas_out_r) + W'(nm_s)) == W'(meas_in_r));
    drain_next_s  = drain_cnt_r + DC_W'(1);
    drain_to_s    = (drain_next_s >= DC_W'(DRAIN_TIMEOUT));
    ovf_s = tin_sat_s[ACC_W] | tout_sat_s[ACC_W] | mout_sat_s[ACC_W] | lat_sat_s[ACC_W]
          | hop_sat_s[ACC_W] | bacc_sat_s[ACC_W]
          | ((phase_r == PH_MEASURE) & min_sat_s[ACC_W]);
  end

  // Run sequencer with all statistics registers; counters only move in active phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r        <= PH_IDLE;
      measure_en_r   <= 1'b0;
      done_r         <= 1'b0;
      timeout_r      <= 1'b0;
      overflow_r     <= 1'b0;
      batch_strobe_r <= 1'b0;
      total_in_r     <= {ACC_W{1'b0}};
      total_out_r    <= {ACC_W{1'b0}};
      meas_in_r      <= {ACC_W{1'b0}};
      meas_out_r     <= {ACC_W{1'b0}};
      lat_sum_r      <= {ACC_W{1'b0}};
      hop_sum_r      <= {ACC_W{1'b0}};
      batch_lat_r    <= {ACC_W{1'b0}};
      batch_acc_r    <= {ACC_W{1'b0}};
      batch_cnt_r    <= {BC_W{1'b0}};
      drain_cnt_r    <= {DC_W{1'b0}};
    end else begin
      case (phase_r)
        PH_IDLE, PH_DONE: begin
          batch_strobe_r <= 1'b0;
          if (start) begin
            phase_r      <= PH_WARMUP;
            measure_en_r <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            overflow_r   <= 1'b0;
            total_in_r   <= {ACC_W{1'b0}};
            total_out_r  <= {ACC_W{1'b0}};
            meas_in_r    <= {ACC_W{1'b0}};
            meas_out_r   <= {ACC_W{1'b0}};
            lat_sum_r    <= {ACC_W{1'b0}};
            hop_sum_r    <= {ACC_W{1'b0}};
            batch_lat_r  <= {ACC_W{1'b0}};
            batch_acc_r  <= {ACC_W{1'b0}};
            batch_cnt_r  <= {BC_W{1'b0}};
            drain_cnt_r  <= {DC_W{1'b0}};
          end
        end
        PH_WARMUP, PH_MEASURE, PH_DRAIN: begin
          total_in_r  <= tin_sat_s[ACC_W-1:0];
          total_out_r <= tout_sat_s[ACC_W-1:0];
          meas_out_r  <= mout_sat_s[ACC_W-1:0];
          lat_sum_r   <= lat_sat_s[ACC_W-1:0];
          hop_sum_r   <= hop_sat_s[ACC_W-1:0];
          overflow_r  <= overflow_r | ovf_s;
          // The whole crossing cycle belongs to the completing batch.
          if (batch_hit_s) begin
            batch_strobe_r <= 1'b1;
            batch_lat_r    <= bacc_sat_s[ACC_W-1:0];
            batch_cnt_r    <= bsum_s - BC_W'(BATCH);
            batch_acc_r    <= {ACC_W{1'b0}};
          end else begin
            batch_strobe_r <= 1'b0;
            batch_cnt_r    <= bsum_s;
            batch_acc_r    <= bacc_sat_s[ACC_W-1:0];
          end
          case (phase_r)
            PH_WARMUP: begin
              if (warm_hit_s) begin
                phase_r      <= PH_MEASURE;
                measure_en_r <= 1'b1;
              end
            end
            PH_MEASURE: begin
              meas_in_r <= min_sat_s[ACC_W-1:0];
              if (meas_hit_s) begin
                phase_r      <= PH_DRAIN;
                measure_en_r <= 1'b0;
              end
            end
            PH_DRAIN: begin
              drain_cnt_r <= drain_next_s;
              // Completion wins over a simultaneous timeout; the residual batch is dropped.
              if (drain_match_s || drain_to_s) begin
                phase_r     <= PH_DONE;
                done_r      <= 1'b1;
                timeout_r   <= ~drain_match_s;
                batch_cnt_r <= {BC_W{1'b0}};
                batch_acc_r <= {ACC_W{1'b0}};
              end
            end
            default: phase_r <= PH_IDLE;
          endcase
        end
        default: begin
          phase_r        <= PH_IDLE;
          measure_en_r   <= 1'b0;
          batch_strobe_r <= 1'b0;
        end
      endcase
    end
  end

  assign net.measure_en = measure_en_r;
  assign phase          = phase_r;
  assign done           = done_r;
  assign timeout        = timeout_r;
  assign overflow       = overflow_r;
  assign total_in       = total_in_r;
  assign total_out      = total_out_r;
  assign meas_in        = meas_in_r;
  assign meas_out       = meas_out_r;
  assign lat_sum        = lat_sum_r;
  assign hop_sum        = hop_sum_r;
  assign batch_strobe   = batch_strobe_r;
  assign batch_lat      = batch_lat_r;

endmodule
